// File: rtl/alu_subtract_serial.sv
// Bit-serial WIDTH-bit subtractor Z = X - Y, one bit per clock, LSB first.
// The start/busy/done handshake gives a 16-cycle latency; Z and the five status flags update only on done.
module alu_subtract_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             Sign,
  output logic             Zero,
  output logic             Borrow,
  output logic             Parity,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic             x_msb;
  logic             y_msb;

  // One-bit adder slice: X + ~Y + 1, with the +1 coming from the initial carry.
  logic             d;
  logic             c_next;
  logic [WIDTH-1:0] rs_next;
  logic             last_bit;

  always_comb begin
    d        = xs[0] ^ ~ys[0] ^ c;
    c_next   = (xs[0] & ~ys[0]) | (xs[0] & c) | (~ys[0] & c);
    rs_next  = {d, rs[WIDTH-1:1]};
    last_bit = (cnt == LAST_BIT);
  end

  // Control and architectural outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Z        <= '0;
      Sign     <= 1'b0;
      Zero     <= 1'b0;
      Borrow   <= 1'b0;
      Parity   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            Z        <= rs_next;
            Sign     <= d;
            Zero     <= (rs_next == '0);
            Borrow   <= ~c_next;
            Parity   <= ~^rs_next;
            Overflow <= (x_msb & ~y_msb & ~d) | (~x_msb & y_msb & d);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the shift registers need no reset; they are always loaded at the accepting edge before being read.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (start) begin
        xs    <= X;
        ys    <= Y;
        rs    <= '0;
        c     <= 1'b1;
        x_msb <= X[WIDTH-1];
        y_msb <= Y[WIDTH-1];
      end
    end else begin
      xs <= xs >> 1;
      ys <= ys >> 1;
      rs <= rs_next;
      c  <= c_next;
    end
  end

  done_single_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  done_not_busy:     assert property (@(posedge clk) disable iff (rst) done |-> !busy);

endmodule

// File: tb/tb_alu_subtract_serial.sv
// Scoreboard bench for alu_subtract_serial: directed vectors queue expected results,
// and a negedge monitor compares on done and checks that outputs hold while busy.
module tb_alu_subtract_serial;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             sign;
    logic             zero;
    logic             borrow;
    logic             parity;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] X, Y;
  logic             busy, done;
  logic [WIDTH-1:0] Z;
  logic             Sign, Zero, Borrow, Parity, Overflow;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  res_t held = '0;

  alu_subtract_serial #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Z(Z),
    .Sign(Sign), .Zero(Zero), .Borrow(Borrow), .Parity(Parity), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic res_t actual();
    return {Z, Sign, Zero, Borrow, Parity, Overflow};
  endfunction

  // Monitor: pop on done, otherwise outputs must hold the last result while busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("z", 32'(Z), 32'(e.z));
          check("flags", 32'({Sign, Zero, Borrow, Parity, Overflow}),
                32'({e.sign, e.zero, e.borrow, e.parity, e.ovf}));
          held = e;
        end
      end else if (busy) begin
        check("hold_while_busy", 32'(actual()), 32'(held));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one accepting edge, then scramble operands.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input res_t e);
    start = 1'b1;
    X = x;
    Y = y;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    X = ~x;
    Y = ~y;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for done; `elapsed` edges since acceptance have already passed.
  task automatic wait_done(input int elapsed);
    int n;
    n = elapsed;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd16);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic run(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input res_t e);
    issue(x, y, e);
    wait_done(0);
    tick();
    check("done_falls", 32'(done), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    X     = 16'h1111;
    Y     = 16'h2222;
    tick();
    tick();
    start = 1'b0;
    rst   = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_outputs", 32'(actual()), 32'd0);

    //            X         Y          Z        S     Zr    B     P     O
    run(16'h0005, 16'h0003, '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    run(16'h1234, 16'h1234, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    run(16'h0000, 16'h0001, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    run(16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    run(16'h7FFF, 16'hFFFF, '{16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});

    // Start during RUN is ignored; start in the done cycle is accepted.
    issue(16'h00FF, 16'h000F, '{16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (4) tick();
    start = 1'b1;
    X = 16'hAAAA;
    Y = 16'h0001;
    tick();
    start = 1'b0;
    wait_done(5);
    issue(16'h0010, 16'h0001, '{16'h000F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    wait_done(0);
    tick();
    check("done_falls_b2b", 32'(done), 32'd0);

    // Reset at E8 discards the run.
    issue(16'h4321, 16'h1234, '{16'h30ED, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (7) tick();
    rst  = 1'b1;
    held = '0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_outputs", 32'(actual()), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run(16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
